// File: rtl/cpu_pkg.sv
// Shared types and defaults for the 16-bit teaching CPU.
package cpu_pkg;

    localparam int CPU_ADDR_W  = 16;
    localparam int CPU_INSTR_W = 16;

    // Encoding of the no-op instruction; ir holds this out of reset.
    localparam logic [CPU_INSTR_W-1:0] NOP = 16'h0000;

    // Fetch controller states.
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HALT  = 2'd1,
        FAULT = 2'd2
    } fetch_state_e;

endpackage : cpu_pkg

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: owns the PC, addresses the combinational ROM,
// latches returned words into ir and hands them to decode over valid/ready.
// Supports redirects from execute, halt/resume and a sticky out-of-range fault.
module ifetch_ctrl
    import cpu_pkg::*;
#(
    parameter int                ADDR_W    = CPU_ADDR_W,
    parameter int                INSTR_W   = CPU_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int                ROM_DEPTH = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    output logic [INSTR_W-1:0] ir,
    output logic [ADDR_W-1:0]  ir_pc,
    output logic               ir_valid,
    input  logic               ir_ready,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_target,
    input  logic               halt_req,
    output logic               halted,
    output logic               fault,
    output logic [15:0]        fetch_count
);

    // One extra bit so ROM_DEPTH == 2**ADDR_W (whole space valid) is representable.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(ROM_DEPTH);

    fetch_state_e        state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [INSTR_W-1:0]  ir_q, ir_d;
    logic [ADDR_W-1:0]   ir_pc_q, ir_pc_d;
    logic                ir_valid_q, ir_valid_d;
    logic [15:0]         cnt_q, cnt_d;

    logic in_range;
    logic can_fetch;
    logic load;

    assign in_range  = {1'b0, pc_q} < DEPTH_L;
    assign can_fetch = !ir_valid_q || ir_ready;

    // Next-state logic: redirect beats load; a held ir is only replaced once consumed.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        cnt_d      = cnt_q;
        load       = 1'b0;

        // Consumption without a refill empties the register.
        if (ir_valid_q && ir_ready)
            ir_valid_d = 1'b0;

        unique case (state_q)
            RUN, HALT: begin
                // A redirect taken in RUN keeps the controller in RUN for that cycle.
                state_d = (halt_req && !(redirect_valid && state_q == RUN)) ? HALT : RUN;
                if (redirect_valid) begin
                    pc_d       = redirect_target;
                    ir_valid_d = 1'b0;
                end else if (!halt_req && can_fetch) begin
                    if (in_range) begin
                        load = 1'b1;
                    end else begin
                        state_d    = FAULT;
                        ir_valid_d = 1'b0;
                    end
                end
            end
            FAULT: ;
            default: state_d = RUN;
        endcase

        if (load) begin
            ir_d       = rom_data;
            ir_pc_d    = pc_q;
            ir_valid_d = 1'b1;
            pc_d       = pc_q + 1'b1;
            cnt_d      = cnt_q + 16'd1;
        end
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            ir_q       <= INSTR_W'(NOP);
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
            cnt_q      <= cnt_d;
        end
    end

    assign rom_addr    = pc_q;
    assign ir          = ir_q;
    assign ir_pc       = ir_pc_q;
    assign ir_valid    = ir_valid_q;
    assign halted      = (state_q == HALT);
    assign fault       = (state_q == FAULT);
    assign fetch_count = cnt_q;

endmodule : ifetch_ctrl

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl: a 256-word instance for flow control and
// fault behaviour, and a full-address-space instance for PC/counter wrap.
module tb_ifetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] rom_addr, rom_data;
    logic [15:0] ir, ir_pc;
    logic        ir_valid, halted, fault;
    logic [15:0] fetch_count;
    logic [15:0] w_rom_addr, w_rom_data;
    logic [15:0] w_ir, w_ir_pc;
    logic        w_ir_valid, w_halted, w_fault;
    logic [15:0] w_fetch_count;
    logic        ir_ready, redirect_valid, halt_req;
    logic [15:0] redirect_target;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Combinational ROM: a few fixed words, everything else addr ^ 5a5a.
    function automatic logic [15:0] rom(input logic [15:0] a);
        case (a)
            16'h0000: rom = 16'ha000;
            16'h0001: rom = 16'h0000;
            16'h0002: rom = 16'hc66b;
            16'h001c: rom = 16'h65f8;
            default:  rom = a ^ 16'h5a5a;
        endcase
    endfunction

    assign rom_data   = rom(rom_addr);
    assign w_rom_data = rom(w_rom_addr);

    ifetch_ctrl #(.ADDR_W(16), .INSTR_W(16), .RESET_PC(16'h0000), .ROM_DEPTH(256)) dut (
        .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr), .rom_data(rom_data),
        .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .halt_req(halt_req), .halted(halted), .fault(fault), .fetch_count(fetch_count)
    );

    ifetch_ctrl #(.ADDR_W(16), .INSTR_W(16), .RESET_PC(16'h0000), .ROM_DEPTH(65536)) dut_w (
        .clk(clk), .rst_n(rst_n), .rom_addr(w_rom_addr), .rom_data(w_rom_data),
        .ir(w_ir), .ir_pc(w_ir_pc), .ir_valid(w_ir_valid), .ir_ready(ir_ready),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .halt_req(halt_req), .halted(w_halted), .fault(w_fault), .fetch_count(w_fetch_count)
    );

    // Advance one edge; outputs are sampled and inputs changed 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ir_ready = 1'b1; redirect_valid = 1'b0; halt_req = 1'b0; redirect_target = '0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ir_ready = 1'b0; redirect_valid = 1'b0; halt_req = 1'b0; redirect_target = '0;
        #3;
        tick();
        chk("reset rom_addr", rom_addr, 16'h0000);
        chk("reset ir", ir, 16'h0000);
        chk("reset ir_pc", ir_pc, 16'h0000);
        chk("reset ir_valid", {15'd0, ir_valid}, 16'd0);
        chk("reset halted", {15'd0, halted}, 16'd0);
        chk("reset fault", {15'd0, fault}, 16'd0);
        chk("reset fetch_count", fetch_count, 16'd0);
    endtask

    task automatic test_stream();
        logic [15:0] exp_ir [3];
        exp_ir[0] = 16'ha000; exp_ir[1] = 16'h0000; exp_ir[2] = 16'hc66b;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stream ir", ir, exp_ir[i]);
            chk("stream ir_pc", ir_pc, 16'(i));
            chk("stream ir_valid", {15'd0, ir_valid}, 16'd1);
        end
        chk("stream fetch_count", fetch_count, 16'd3);
    endtask

    task automatic test_backpressure();
        do_reset();
        tick();
        chk("bp first ir", ir, 16'ha000);
        ir_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp ir held", ir, 16'ha000);
            chk("bp ir_valid", {15'd0, ir_valid}, 16'd1);
            chk("bp pc frozen", rom_addr, 16'h0001);
            chk("bp count frozen", fetch_count, 16'd1);
        end
        ir_ready = 1'b1;
        tick();
        chk("bp release ir", ir, 16'h0000);
        chk("bp release ir_pc", ir_pc, 16'h0001);
        chk("bp release count", fetch_count, 16'd2);
    endtask

    // Continues from test_backpressure: ir=0000 held valid, PC=2, count=2.
    task automatic test_redirect();
        ir_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 16'h001c;
        tick();
        chk("redir kill valid", {15'd0, ir_valid}, 16'd0);
        chk("redir pc", rom_addr, 16'h001c);
        chk("redir count", fetch_count, 16'd2);
        redirect_valid = 1'b0;
        tick();
        chk("redir target ir", ir, 16'h65f8);
        chk("redir target ir_pc", ir_pc, 16'h001c);
        chk("redir target valid", {15'd0, ir_valid}, 16'd1);
        chk("redir target count", fetch_count, 16'd3);
        // Redirect together with ir_ready: consumed, no load this cycle.
        ir_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 16'h0002;
        tick();
        chk("redir+ready valid", {15'd0, ir_valid}, 16'd0);
        chk("redir+ready count", fetch_count, 16'd3);
        chk("redir+ready pc", rom_addr, 16'h0002);
        redirect_valid = 1'b0;
        tick();
        chk("redir2 ir", ir, 16'hc66b);
        chk("redir2 ir_pc", ir_pc, 16'h0002);
        chk("redir2 count", fetch_count, 16'd4);
    endtask

    // Continues from test_redirect: ir=c66b valid, PC=3, count=4.
    task automatic test_halt();
        ir_ready = 1'b0; halt_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("halt halted", {15'd0, halted}, 16'd1);
            chk("halt ir held", ir, 16'hc66b);
            chk("halt valid held", {15'd0, ir_valid}, 16'd1);
            chk("halt pc", rom_addr, 16'h0003);
            chk("halt count", fetch_count, 16'd4);
        end
        halt_req = 1'b0; ir_ready = 1'b1;
        tick();
        chk("resume halted", {15'd0, halted}, 16'd0);
        chk("resume ir", ir, 16'h5a59);
        chk("resume ir_pc", ir_pc, 16'h0003);
        chk("resume count", fetch_count, 16'd5);
    endtask

    task automatic test_fault();
        redirect_valid = 1'b1; redirect_target = 16'h0100;
        tick();
        chk("fault not yet", {15'd0, fault}, 16'd0);
        chk("fault pc", rom_addr, 16'h0100);
        redirect_valid = 1'b0;
        tick();
        chk("fault set", {15'd0, fault}, 16'd1);
        chk("fault valid", {15'd0, ir_valid}, 16'd0);
        chk("fault count", fetch_count, 16'd5);
        redirect_valid = 1'b1; redirect_target = 16'h0000;
        tick();
        chk("fault redir ignored", rom_addr, 16'h0100);
        chk("fault sticky", {15'd0, fault}, 16'd1);
        redirect_valid = 1'b0;
        tick();
        chk("fault still pc", rom_addr, 16'h0100);
        do_reset();
        chk("fault reset clears", {15'd0, fault}, 16'd0);
        chk("fault reset pc", rom_addr, 16'h0000);
    endtask

    task automatic test_wrap();
        do_reset();
        redirect_valid = 1'b1; redirect_target = 16'hffff;
        tick();
        chk("wrap redir pc", w_rom_addr, 16'hffff);
        redirect_valid = 1'b0;
        tick();
        chk("wrap ir_pc", w_ir_pc, 16'hffff);
        chk("wrap ir", w_ir, 16'ha5a5);
        chk("wrap next pc", w_rom_addr, 16'h0000);
        chk("wrap count1", w_fetch_count, 16'd1);
        tick();
        chk("wrap ir after", w_ir, 16'ha000);
        chk("wrap count2", w_fetch_count, 16'd2);
        for (int i = 0; i < 65533; i++) tick();
        chk("count at max", w_fetch_count, 16'hffff);
        tick();
        chk("count wraps", w_fetch_count, 16'h0000);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_halt();
        test_fault();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_ifetch_ctrl
